// File: rtl/mips_complete.sv
// Single-cycle MIPS subset (add/sub/and/or/slt, lw, sw, beq, addi, j).
// Every datapath node is exposed as a port; only PC, register file and data memory hold state.
module mips_imem (
  input  logic [5:0]  addr_i,
  output logic [31:0] rd_o
);
  // Program image is loaded externally into Memory through the hierarchical path im.Memory.
  logic [31:0] Memory [0:63];

  assign rd_o = Memory[addr_i];
endmodule

module mips_complete (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PCNext,
  output logic [31:0] PC,
  output logic [31:0] PCplus4,
  output logic [31:0] Instr,
  output logic [31:0] Signlmm,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] shifted,
  output logic [31:0] PCBranch,
  output logic [31:0] SrcB,
  output logic [31:0] ALUResult,
  output logic [31:0] ReadData,
  output logic [31:0] Result,
  output logic [4:0]  WriteReg,
  output logic [2:0]  ALUControl,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        Branch,
  output logic        ALUSrc,
  output logic        Jump,
  output logic        Zero,
  output logic        PCSrc
);
  logic [31:0] pc_q;
  logic [31:0] rf_q   [0:31];
  logic [31:0] dmem_q [0:63];
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        unused_shamt;

  mips_imem im (
    .addr_i (pc_q[7:2]),
    .rd_o   (Instr)
  );

  assign op           = Instr[31:26];
  assign funct        = Instr[5:0];
  assign rs           = Instr[25:21];
  assign rt           = Instr[20:16];
  assign unused_shamt = ^Instr[10:6];

  assign PC       = pc_q;
  assign PCplus4  = pc_q + 32'd4;
  assign Signlmm  = {{16{Instr[15]}}, Instr[15:0]};
  assign shifted  = {Signlmm[29:0], 2'b00};
  assign PCBranch = PCplus4 + shifted;

  // Main decoder: unknown opcodes fall through to an all-zero no-op.
  always_comb begin
    {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump} = 7'b0000000;
    case (op)
      6'b000000: {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump} = 7'b1100000;
      6'b100011: {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump} = 7'b1010010;
      6'b101011: {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump} = 7'b0010100;
      6'b000100: {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump} = 7'b0001000;
      6'b001000: {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump} = 7'b1010000;
      6'b000010: {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump} = 7'b0000001;
      default:   ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b010;
    if (op == 6'b000100) begin
      ALUControl = 3'b110;
    end else if (op == 6'b000000) begin
      case (funct)
        6'b100010: ALUControl = 3'b110;
        6'b100100: ALUControl = 3'b000;
        6'b100101: ALUControl = 3'b001;
        6'b101010: ALUControl = 3'b111;
        default:   ALUControl = 3'b010;
      endcase
    end
  end

  // $0 is forced to zero on read, so its storage content never matters.
  assign ReadData1 = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign ReadData2 = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign SrcB      = ALUSrc ? Signlmm : ReadData2;

  always_comb begin
    ALUResult = ReadData1 + SrcB;
    case (ALUControl)
      3'b110:  ALUResult = ReadData1 - SrcB;
      3'b000:  ALUResult = ReadData1 & SrcB;
      3'b001:  ALUResult = ReadData1 | SrcB;
      3'b111:  ALUResult = ($signed(ReadData1) < $signed(SrcB)) ? 32'd1 : 32'd0;
      default: ALUResult = ReadData1 + SrcB;
    endcase
  end

  assign Zero     = (ALUResult == 32'd0);
  assign PCSrc    = Branch & Zero;
  assign ReadData = dmem_q[ALUResult[7:2]];
  assign Result   = MemtoReg ? ReadData : ALUResult;
  assign WriteReg = RegDst ? Instr[15:11] : Instr[20:16];

  always_comb begin
    PCNext = PCplus4;
    if (Jump) begin
      PCNext = {PCplus4[31:28], Instr[25:0], 2'b00};
    end else if (PCSrc) begin
      PCNext = PCBranch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= PCNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (RegWrite && (WriteReg != 5'd0)) begin
      rf_q[WriteReg] <= Result;
    end
  end

  // Data memory keeps its contents through reset; only the write is blocked.
  always_ff @(posedge clk) begin
    if (!reset && MemWrite) begin
      dmem_q[ALUResult[7:2]] <= ReadData2;
    end
  end
endmodule

// File: tb/tb_mips_complete.sv
module tb_mips_complete;
  logic        clk;
  logic        reset;
  logic [31:0] PCNext, PC, PCplus4, Instr, Signlmm, ReadData1, ReadData2, shifted;
  logic [31:0] PCBranch, SrcB, ALUResult, ReadData, Result;
  logic [4:0]  WriteReg;
  logic [2:0]  ALUControl;
  logic        RegWrite, RegDst, MemtoReg, MemWrite, Branch, ALUSrc, Jump, Zero, PCSrc;

  mips_complete dut (
    .clk(clk), .reset(reset), .PCNext(PCNext), .PC(PC), .PCplus4(PCplus4), .Instr(Instr),
    .Signlmm(Signlmm), .ReadData1(ReadData1), .ReadData2(ReadData2), .shifted(shifted),
    .PCBranch(PCBranch), .SrcB(SrcB), .ALUResult(ALUResult), .ReadData(ReadData),
    .Result(Result), .WriteReg(WriteReg), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Branch(Branch),
    .ALUSrc(ALUSrc), .Jump(Jump), .Zero(Zero), .PCSrc(PCSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    S_PC, S_PCNEXT, S_INSTR, S_SIGNIMM, S_SHIFTED, S_PCBRANCH, S_RD1, S_RD2, S_ALURES,
    S_READDATA, S_RESULT, S_WRITEREG, S_ALUCTL, S_REGWRITE, S_REGDST, S_MEMTOREG,
    S_MEMWRITE, S_ALUSRC, S_JUMP, S_ZERO, S_PCSRC
  } sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t scoreboard_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc_cnt    = 0;
  bit   running    = 1'b0;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_PC:       return PC;
      S_PCNEXT:   return PCNext;
      S_INSTR:    return Instr;
      S_SIGNIMM:  return Signlmm;
      S_SHIFTED:  return shifted;
      S_PCBRANCH: return PCBranch;
      S_RD1:      return ReadData1;
      S_RD2:      return ReadData2;
      S_ALURES:   return ALUResult;
      S_READDATA: return ReadData;
      S_RESULT:   return Result;
      S_WRITEREG: return {27'd0, WriteReg};
      S_ALUCTL:   return {29'd0, ALUControl};
      S_REGWRITE: return {31'd0, RegWrite};
      S_REGDST:   return {31'd0, RegDst};
      S_MEMTOREG: return {31'd0, MemtoReg};
      S_MEMWRITE: return {31'd0, MemWrite};
      S_ALUSRC:   return {31'd0, ALUSrc};
      S_JUMP:     return {31'd0, Jump};
      S_ZERO:     return {31'd0, Zero};
      default:    return {31'd0, PCSrc};
    endcase
  endfunction

  task automatic expect_at(input int c, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    scoreboard_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (running) begin
      while (scoreboard_q.size() > 0 && scoreboard_q[0].cyc == cyc_cnt) begin
        exp_t e;
        logic [31:0] act;
        e = scoreboard_q.pop_front();
        act = observe(e.sig);
        compared++;
        if (act !== e.val) begin
          mismatched++;
          $display("FAIL cyc %0d %s: got %08h expected %08h", cyc_cnt, e.sig.name(), act, e.val);
        end else begin
          $display("ok   cyc %0d %s = %08h", cyc_cnt, e.sig.name(), act);
        end
      end
      cyc_cnt++;
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.im.Memory[i] = 32'h0000_0000;
    dut.im.Memory[0]  = 32'h2008_0005;
    dut.im.Memory[1]  = 32'h0108_4820;
    dut.im.Memory[2]  = 32'hac09_0004;
    dut.im.Memory[3]  = 32'h8c0a_0004;
    dut.im.Memory[4]  = 32'h1108_0001;
    dut.im.Memory[5]  = 32'h200b_0001;
    dut.im.Memory[6]  = 32'h1109_0001;
    dut.im.Memory[7]  = 32'h2000_0007;
    dut.im.Memory[8]  = 32'h000a_5820;
    dut.im.Memory[9]  = 32'h0109_5022;
    dut.im.Memory[10] = 32'h0109_582a;
    dut.im.Memory[11] = 32'h0109_6024;
    dut.im.Memory[12] = 32'h0109_6825;
    dut.im.Memory[13] = 32'h0800_0000;

    expect_at(0, S_PC, 32'h0);          expect_at(0, S_INSTR, 32'h2008_0005);
    expect_at(0, S_ALUSRC, 32'd1);      expect_at(0, S_ALURES, 32'h5);
    expect_at(0, S_REGWRITE, 32'd1);    expect_at(0, S_SIGNIMM, 32'h5);
    expect_at(0, S_SHIFTED, 32'h14);    expect_at(0, S_PCNEXT, 32'h4);
    expect_at(1, S_PC, 32'h4);          expect_at(1, S_RD1, 32'h5);
    expect_at(1, S_ALUCTL, 32'd2);      expect_at(1, S_ALURES, 32'ha);
    expect_at(1, S_WRITEREG, 32'd9);    expect_at(1, S_REGDST, 32'd1);
    expect_at(2, S_MEMWRITE, 32'd1);    expect_at(2, S_ALURES, 32'h4);
    expect_at(2, S_RD2, 32'ha);         expect_at(2, S_REGWRITE, 32'd0);
    expect_at(3, S_READDATA, 32'ha);    expect_at(3, S_MEMTOREG, 32'd1);
    expect_at(3, S_RESULT, 32'ha);      expect_at(3, S_WRITEREG, 32'd10);
    expect_at(4, S_PC, 32'h10);         expect_at(4, S_ZERO, 32'd1);
    expect_at(4, S_PCSRC, 32'd1);       expect_at(4, S_PCBRANCH, 32'h18);
    expect_at(4, S_PCNEXT, 32'h18);     expect_at(4, S_ALUCTL, 32'd6);
    expect_at(5, S_PC, 32'h18);         expect_at(5, S_ZERO, 32'd0);
    expect_at(5, S_PCSRC, 32'd0);       expect_at(5, S_PCNEXT, 32'h1c);
    expect_at(6, S_WRITEREG, 32'd0);    expect_at(6, S_ALURES, 32'h7);
    expect_at(7, S_RD1, 32'h0);         expect_at(7, S_RD2, 32'ha);
    expect_at(7, S_ALURES, 32'ha);
    expect_at(8, S_ALURES, 32'hffff_fffb);
    expect_at(9, S_ALURES, 32'h1);      expect_at(9, S_ALUCTL, 32'd7);
    expect_at(10, S_ALURES, 32'h0);     expect_at(10, S_ZERO, 32'd1);
    expect_at(11, S_ALURES, 32'hf);     expect_at(11, S_ALUCTL, 32'd1);
    expect_at(12, S_JUMP, 32'd1);       expect_at(12, S_PCNEXT, 32'h0);
    expect_at(13, S_PC, 32'h0);         expect_at(13, S_INSTR, 32'h2008_0005);
    expect_at(15, S_PC, 32'h8);         expect_at(15, S_MEMWRITE, 32'd1);
    expect_at(16, S_PC, 32'h0);         expect_at(16, S_INSTR, 32'h8c0e_0004);
    expect_at(16, S_READDATA, 32'ha);   expect_at(16, S_RD1, 32'h0);
    expect_at(17, S_PC, 32'h4);         expect_at(17, S_RD1, 32'h0);
    expect_at(17, S_ALURES, 32'h0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    running = 1'b1;
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    dut.im.Memory[0] = 32'h8c0e_0004;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (PC !== 32'h0000_000c) begin
      mismatched++;
      $display("FAIL final PC: got %08h expected 0000000c", PC);
    end else begin
      $display("ok   final PC = %08h", PC);
    end
    compared++;
    if (Instr !== 32'h8c0a_0004) begin
      mismatched++;
      $display("FAIL final Instr: got %08h expected 8c0a0004", Instr);
    end else begin
      $display("ok   final Instr = %08h", Instr);
    end
    compared++;
    if (ALUResult !== 32'h0000_0004) begin
      mismatched++;
      $display("FAIL final ALUResult: got %08h expected 00000004", ALUResult);
    end else begin
      $display("ok   final ALUResult = %08h", ALUResult);
    end
    compared++;
    if (dut.rf_q[14] !== 32'h0000_000a) begin
      mismatched++;
      $display("FAIL final $14: got %08h expected 0000000a", dut.rf_q[14]);
    end else begin
      $display("ok   final $14 = %08h", dut.rf_q[14]);
    end
    while (scoreboard_q.size() > 0) begin
      exp_t e;
      e = scoreboard_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL cyc %0d %s: never checked, expected %08h", e.cyc, e.sig.name(), e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
